// File: rtl/tick_counter_sequencer.sv
// Counter sequencer on a single clock: prescaler tick enables drive
// run/stop/step/load control of a small up/down counter.
module tick_counter_sequencer #(
  parameter int DIV   = 50_000_000,
  parameter int WIDTH = 3
) (
  input  logic             clk_50MHz,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             dir,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out_counter,
  output logic             tick,
  output logic             running,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  state_t           st;
  state_t           nxt_st;
  logic [PW-1:0]    prescaler;
  logic [PW-1:0]    nxt_pre;
  logic [WIDTH-1:0] nxt_cnt;
  logic [WIDTH-1:0] cnt_val;
  logic             at_term;
  logic             nxt_tick;

  assign state = st;

  // Next-state decode; load outranks stop, stop outranks start, start outranks step.
  always_comb begin
    cnt_val  = dir ? out_counter + WIDTH'(1)
                   : out_counter - WIDTH'(1);
    at_term  = dir ? (cnt_val == '1) : (cnt_val == '0);
    nxt_st   = st;
    nxt_pre  = prescaler;
    nxt_cnt  = out_counter;
    nxt_tick = 1'b0;
    if (load) begin
      nxt_cnt = load_value;
      nxt_pre = '0;
      nxt_st  = (st == RUN) ? RUN : IDLE;
    end else begin
      unique case (st)
        IDLE: begin
          nxt_pre = '0;
          if (stop) begin
            nxt_st = IDLE;
          end else if (start) begin
            nxt_st = RUN;
          end else if (step) begin
            nxt_st   = STEP;
            nxt_cnt  = cnt_val;
            nxt_tick = 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            nxt_st  = IDLE;
            nxt_pre = '0;
          end else if (prescaler == PRE_LAST) begin
            nxt_pre  = '0;
            nxt_cnt  = cnt_val;
            nxt_tick = 1'b1;
            if (one_shot && at_term) nxt_st = DONE;
          end else begin
            nxt_pre = prescaler + PW'(1);
          end
        end
        STEP: begin
          nxt_st  = IDLE;
          nxt_pre = '0;
        end
        DONE: begin
          nxt_pre = '0;
          if (stop) nxt_st = IDLE;
          else if (start) nxt_st = RUN;
        end
        default: begin
          nxt_st  = IDLE;
          nxt_pre = '0;
        end
      endcase
    end
  end

  // State, prescaler and all outputs register together.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      st          <= IDLE;
      prescaler   <= '0;
      out_counter <= '0;
      tick        <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      st          <= nxt_st;
      prescaler   <= nxt_pre;
      out_counter <= nxt_cnt;
      tick        <= nxt_tick;
      running     <= (nxt_st == RUN);
      done        <= (nxt_st == DONE);
    end
  end

endmodule

// File: tb/tb_tick_counter_sequencer.sv
// Bench for tick_counter_sequencer with DIV=4, WIDTH=3, checked
// against a cycle-countdown reference model.
module tb_tick_counter_sequencer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step = 1'b0;
  logic       dir = 1'b1;
  logic       one_shot = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_value = 3'd0;
  logic [2:0] out_counter;
  logic       tick;
  logic       running;
  logic       done;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  // model: 0 idle, 1 run, 2 step, 3 done
  int m_state = 0;
  int m_cnt = 0;
  int m_left = 0;
  bit m_tick = 1'b0;

  tick_counter_sequencer #(.DIV(DIV), .WIDTH(3)) dut (
    .clk_50MHz  (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .dir        (dir),
    .one_shot   (one_shot),
    .load       (load),
    .load_value (load_value),
    .out_counter(out_counter),
    .tick       (tick),
    .running    (running),
    .done       (done),
    .state      (state)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_left  = 0;
    m_tick  = 1'b0;
  endfunction

  function automatic void model_count();
    if (dir) m_cnt = (m_cnt + 1) % 8;
    else     m_cnt = (m_cnt + 7) % 8;
    m_tick = 1'b1;
  endfunction

  function automatic void model_step();
    bit term;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_tick = 1'b0;
    if (load) begin
      m_cnt  = int'(load_value);
      m_left = DIV;
      if (m_state != 1) m_state = 0;
      return;
    end
    case (m_state)
      0: begin
        if (stop) m_state = 0;
        else if (start) begin
          m_state = 1;
          m_left  = DIV;
        end else if (step) begin
          model_count();
          m_state = 2;
        end
      end
      1: begin
        if (stop) m_state = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_left = DIV;
            model_count();
            term = dir ? (m_cnt == 7) : (m_cnt == 0);
            if (one_shot && term) m_state = 3;
          end
        end
      end
      2: m_state = 0;
      default: begin
        if (stop) m_state = 0;
        else if (start) begin
          m_state = 1;
          m_left  = DIV;
        end
      end
    endcase
  endfunction

  function automatic logic [7:0] model_vec();
    logic [2:0] c;
    c = m_cnt[2:0];
    return {2'(m_state), m_state == 1, m_state == 3, m_tick, c};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {state, running, done, tick, out_counter};
  endfunction

  task automatic cycle(input bit i_start, input bit i_stop,
                       input bit i_step, input bit i_load,
                       input int i_val);
    @(negedge clk);
    start      = i_start;
    stop       = i_stop;
    step       = i_step;
    load       = i_load;
    load_value = i_val[2:0];
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dut_vec() !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_hold: got %h want 00", dut_vec());
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (3) begin
      idle();
      n_checks++;
      if (dut_vec() !== 8'h00) begin
        n_errors++;
        $display("FAIL reset_idle: got %h want 00", dut_vec());
      end
    end
  endtask

  task automatic test_free_run();
    dir = 1'b1;
    one_shot = 1'b0;
    cycle(1, 0, 0, 0, 0);
    n_checks++;
    if (running !== 1'b1 || state !== 2'd1) begin
      n_errors++;
      $display("FAIL run_enter: running=%b state=%0d want 1/1",
               running, state);
    end
    for (int k = 1; k <= 34; k++) begin
      idle();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++;
        $display("FAIL free_run k=%0d: got %h want %h",
                 k, dut_vec(), model_vec());
      end
      if (k == 4) begin
        n_checks++;
        if (out_counter !== 3'd1 || tick !== 1'b1) begin
          n_errors++;
          $display("FAIL first_count: cnt=%0d tick=%b want 1/1",
                   out_counter, tick);
        end
      end
      if (k == 32) begin
        n_checks++;
        if (out_counter !== 3'd0 || tick !== 1'b1) begin
          n_errors++;
          $display("FAIL wrap: cnt=%0d tick=%b want 0/1",
                   out_counter, tick);
        end
      end
    end
  endtask

  task automatic test_one_shot_down();
    logic [2:0] seen[$];
    logic [2:0] want[5];
    want = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 5);
    n_checks++;
    if (out_counter !== 3'd5 || state !== 2'd0 || tick !== 1'b0) begin
      n_errors++;
      $display("FAIL load5: cnt=%0d state=%0d tick=%b want 5/0/0",
               out_counter, state, tick);
    end
    dir = 1'b0;
    one_shot = 1'b1;
    cycle(1, 0, 0, 0, 0);
    for (int k = 1; k <= 44; k++) begin
      idle();
      if (tick) seen.push_back(out_counter);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++;
        $display("FAIL one_shot k=%0d: got %h want %h",
                 k, dut_vec(), model_vec());
      end
      if (k > 20) begin
        n_checks++;
        if (state !== 2'd3 || done !== 1'b1 || out_counter !== 3'd0 ||
            tick !== 1'b0) begin
          n_errors++;
          $display("FAIL done_hold k=%0d: st=%0d done=%b cnt=%0d tick=%b",
                   k, state, done, out_counter, tick);
        end
      end
    end
    n_checks++;
    if (seen.size() != 5) begin
      n_errors++;
      $display("FAIL down_seq_len: got %0d want 5", seen.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (seen[i] !== want[i]) begin
          n_errors++;
          $display("FAIL down_seq[%0d]: got %0d want %0d",
                   i, seen[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_step();
    cycle(0, 0, 0, 1, 0);
    n_checks++;
    if (state !== 2'd0 || out_counter !== 3'd0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL done_load: st=%0d cnt=%0d done=%b want 0/0/0",
               state, out_counter, done);
    end
    dir = 1'b1;
    one_shot = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 0, 1, 0, 0);
      n_checks++;
      if (out_counter !== 3'(i) || tick !== 1'b1 || state !== 2'd2) begin
        n_errors++;
        $display("FAIL step%0d: cnt=%0d tick=%b st=%0d want %0d/1/2",
                 i, out_counter, tick, state, i);
      end
      repeat (3) begin
        idle();
        n_checks++;
        if (out_counter !== 3'(i) || tick !== 1'b0 || state !== 2'd0) begin
          n_errors++;
          $display("FAIL step%0d_gap: cnt=%0d tick=%b st=%0d", i,
                   out_counter, tick, state);
        end
      end
    end
  endtask

  task automatic test_stop_mid();
    int k;
    one_shot = 1'b0;
    dir = 1'b1;
    cycle(1, 0, 0, 0, 0);
    repeat (3) idle();
    cycle(0, 1, 0, 0, 0);
    n_checks++;
    if (state !== 2'd0 || tick !== 1'b0 || out_counter !== 3'd3) begin
      n_errors++;
      $display("FAIL stop_mid: st=%0d tick=%b cnt=%0d want 0/0/3",
               state, tick, out_counter);
    end
    repeat (5) idle();
    cycle(1, 0, 0, 0, 0);
    k = 0;
    while (!tick && k < 12) begin
      idle();
      k++;
    end
    n_checks++;
    if (k != 4 || out_counter !== 3'd4) begin
      n_errors++;
      $display("FAIL restart_latency: got %0d cyc cnt=%0d want 4/4",
               k, out_counter);
    end
  endtask

  task automatic test_load_priority();
    int k;
    repeat (2) idle();
    cycle(1, 1, 1, 1, 6);
    n_checks++;
    if (out_counter !== 3'd6 || state !== 2'd1 || tick !== 1'b0) begin
      n_errors++;
      $display("FAIL load_prio: cnt=%0d st=%0d tick=%b want 6/1/0",
               out_counter, state, tick);
    end
    k = 0;
    while (!tick && k < 12) begin
      idle();
      k++;
    end
    n_checks++;
    if (k != 4 || out_counter !== 3'd7) begin
      n_errors++;
      $display("FAIL load_latency: got %0d cyc cnt=%0d want 4/7",
               k, out_counter);
    end
  endtask

  task automatic test_async_reset();
    idle();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec() !== 8'h00) begin
      n_errors++;
      $display("FAIL async_reset: got %h want 00", dut_vec());
    end
    model_reset();
    repeat (3) idle();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      idle();
      n_checks++;
      if (dut_vec() !== 8'h00) begin
        n_errors++;
        $display("FAIL post_reset k=%0d: got %h want 00", k, dut_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) one_shot = 1'($urandom_range(0, 1));
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 13) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            int'($urandom_range(0, 7)));
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++;
        $display("FAIL random i=%0d: got %h want %h",
                 i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_one_shot_down();
    test_step();
    test_stop_mid();
    test_load_priority();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
